// File: rtl/shift_operand_pkg.sv
// Shared types for the ARM shifter-operand pipe: shift type codes, decoded-op
// kinds and the record handed from decode to the shift core.
package shift_operand_pkg;

  localparam logic [1:0] LSL = 2'd0;
  localparam logic [1:0] LSR = 2'd1;
  localparam logic [1:0] ASR = 2'd2;
  localparam logic [1:0] ROR = 2'd3;

  typedef enum logic [2:0] {
    MEM,
    IMM_ROT,
    IMM_SH,
    REG_SH,
    RRX
  } op_kind_e;

  // For MEM and IMM_ROT the rm field carries the already-extended constant.
  typedef struct packed {
    op_kind_e   kind;
    logic [1:0] sh_type;
    logic [7:0] amt;
    logic [31:0] rm;
    logic       c_in;
  } decoded_op_t;

  function automatic logic [31:0] ror32(input logic [31:0] v, input logic [4:0] r);
    logic [63:0] d;
    d = {v, v} >> r;
    return d[31:0];
  endfunction

endpackage

// File: rtl/shift_operand_pipe_core.sv
// Combinational barrel shifter: decoded op in, operand 2 and shifter carry out.
module shift_core
  import shift_operand_pkg::*;
(
  input  decoded_op_t op,
  output logic [31:0] val2,
  output logic        c_out
);

  logic [32:0] lsl_v;
  logic [32:0] lsr_v;
  logic [32:0] asr_v;
  logic [31:0] ror_v;

  // The extra bit of each 33-bit vector catches the last bit shifted out,
  // so amounts of 32 and beyond fall out naturally without range checks.
  assign lsl_v = {1'b0, op.rm} << op.amt;
  assign lsr_v = {op.rm, 1'b0} >> op.amt;
  assign asr_v = 33'($signed({op.rm, 1'b0}) >>> op.amt);
  assign ror_v = ror32(op.rm, op.amt[4:0]);

  always_comb begin
    val2  = op.rm;
    c_out = op.c_in;
    case (op.kind)
      IMM_ROT: begin
        val2 = ror_v;
        if (op.amt != 8'd0) c_out = ror_v[31];
      end
      RRX: begin
        val2  = {op.c_in, op.rm[31:1]};
        c_out = op.rm[0];
      end
      IMM_SH, REG_SH: begin
        if (op.amt != 8'd0) begin
          case (op.sh_type)
            LSL:     {c_out, val2} = lsl_v;
            LSR:     {val2, c_out} = lsr_v;
            ASR:     {val2, c_out} = asr_v;
            default: begin
              val2  = ror_v;
              c_out = ror_v[31];
            end
          endcase
        end
      end
      default: begin
        val2  = op.rm;
        c_out = op.c_in;
      end
    endcase
  end

endmodule

// File: rtl/shift_operand_pipe.sv
// Elastic shifter-operand pipe: decodes the ARM operand-2 encoding, optionally
// registers the decoded op, shifts, and holds the result in an output register.
module shift_operand_pipe
  import shift_operand_pkg::*;
#(
  parameter int PIPE_STAGES  = 1,
  parameter int TAG_W        = 4,
  parameter bit MEM_SIGN_EXT = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      val_rm,
  input  logic [31:0]      val_rs,
  input  logic [11:0]      shift_operand,
  input  logic             imm,
  input  logic             mem_mode,
  input  logic             c_in,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      val2,
  output logic             c_out,
  output logic [TAG_W-1:0] out_tag
);

  decoded_op_t      dec;
  decoded_op_t      core_op;
  logic             core_valid;
  logic [TAG_W-1:0] core_tag;
  logic [31:0]      core_val2;
  logic             core_c;
  logic             out_free;
  logic             rs_unused;

  assign rs_unused = ^val_rs[31:8];
  assign out_free  = !out_valid || out_ready;

  // Immediate-shift #0 encodings are rewritten here (LSR/ASR -> 32, ROR -> RRX)
  // so the core treats immediate and register shifts identically.
  always_comb begin
    dec         = '0;
    dec.rm      = val_rm;
    dec.c_in    = c_in;
    dec.sh_type = shift_operand[6:5];
    if (mem_mode) begin
      dec.kind = MEM;
      dec.rm   = MEM_SIGN_EXT ? {{20{shift_operand[11]}}, shift_operand}
                              : {20'd0, shift_operand};
    end else if (imm) begin
      dec.kind = IMM_ROT;
      dec.rm   = {24'd0, shift_operand[7:0]};
      dec.amt  = {3'd0, shift_operand[11:8], 1'b0};
    end else if (!shift_operand[4]) begin
      if (shift_operand[11:7] == 5'd0 && dec.sh_type == ROR) begin
        dec.kind = RRX;
      end else begin
        dec.kind = IMM_SH;
        dec.amt  = {3'd0, shift_operand[11:7]};
        if (shift_operand[11:7] == 5'd0 && (dec.sh_type == LSR || dec.sh_type == ASR))
          dec.amt = 8'd32;
      end
    end else begin
      dec.kind = REG_SH;
      dec.amt  = val_rs[7:0];
    end
  end

  generate
    if (PIPE_STAGES == 1) begin : g_one
      assign core_op    = dec;
      assign core_valid = in_valid;
      assign core_tag   = in_tag;
      assign in_ready   = out_free;
    end else if (PIPE_STAGES == 2) begin : g_two
      logic             s1_valid;
      decoded_op_t      s1_op;
      logic [TAG_W-1:0] s1_tag;
      logic             s1_load;

      assign s1_load = !s1_valid || out_free;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          s1_valid <= 1'b0;
          s1_op    <= '0;
          s1_tag   <= '0;
        end else if (flush) begin
          s1_valid <= 1'b0;
        end else if (s1_load) begin
          s1_valid <= in_valid;
          if (in_valid) begin
            s1_op  <= dec;
            s1_tag <= in_tag;
          end
        end
      end

      assign core_op    = s1_op;
      assign core_valid = s1_valid;
      assign core_tag   = s1_tag;
      assign in_ready   = s1_load;
    end else begin : g_bad
      $error("shift_operand_pipe: PIPE_STAGES must be 1 or 2");
      assign core_op    = '0;
      assign core_valid = 1'b0;
      assign core_tag   = '0;
      assign in_ready   = 1'b0;
    end
  endgenerate

  shift_core u_core (
    .op    (core_op),
    .val2  (core_val2),
    .c_out (core_c)
  );

  // Data only updates on a real load so the result stays put under backpressure.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      val2      <= '0;
      c_out     <= 1'b0;
      out_tag   <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (out_free) begin
      out_valid <= core_valid;
      if (core_valid) begin
        val2    <= core_val2;
        c_out   <= core_c;
        out_tag <= core_tag;
      end
    end
  end

endmodule

// File: tb/tb_shift_operand_pipe.sv
// Self-checking bench: a two-stage sign-extending pipe and a one-stage
// zero-extending pipe share stimulus; each has its own reference scoreboard.
module tb_shift_operand_pipe;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, out_ready;
  logic [31:0] val_rm, val_rs;
  logic [11:0] shift_operand;
  logic        imm, mem_mode, c_in;
  logic [3:0]  in_tag;

  logic        in_ready_a, out_valid_a, c_out_a;
  logic [31:0] val2_a;
  logic [3:0]  out_tag_a;
  logic        in_ready_b, out_valid_b, c_out_b;
  logic [31:0] val2_b;
  logic [3:0]  out_tag_b;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [31:0] v;
    logic        c;
    logic [3:0]  tag;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];

  always #5 clk = ~clk;

  shift_operand_pipe #(.PIPE_STAGES(2), .TAG_W(4), .MEM_SIGN_EXT(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_a),
    .val_rm(val_rm), .val_rs(val_rs), .shift_operand(shift_operand), .imm(imm),
    .mem_mode(mem_mode), .c_in(c_in), .in_tag(in_tag), .out_valid(out_valid_a),
    .out_ready(out_ready), .val2(val2_a), .c_out(c_out_a), .out_tag(out_tag_a));

  shift_operand_pipe #(.PIPE_STAGES(1), .TAG_W(4), .MEM_SIGN_EXT(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_b),
    .val_rm(val_rm), .val_rs(val_rs), .shift_operand(shift_operand), .imm(imm),
    .mem_mode(mem_mode), .c_in(c_in), .in_tag(in_tag), .out_valid(out_valid_b),
    .out_ready(out_ready), .val2(val2_b), .c_out(c_out_b), .out_tag(out_tag_b));

  function automatic logic [31:0] rotr(input logic [31:0] v, input int n);
    return (n == 0) ? v : ((v >> n) | (v << (32 - n)));
  endfunction

  // Reference written straight from the ARM operand-2 rules; returns {c, val}.
  function automatic logic [32:0] ref_op(input logic [31:0] rm, input logic [31:0] rs,
                                         input logic [11:0] so, input logic im,
                                         input logic mem, input logic c, input bit se);
    logic [31:0] v;
    logic        co;
    int          n;
    v  = rm;
    co = c;
    if (mem) begin
      v = se ? {{20{so[11]}}, so} : {20'd0, so};
    end else if (im) begin
      v  = rotr({24'd0, so[7:0]}, 2 * int'(so[11:8]));
      co = (so[11:8] == 4'd0) ? c : v[31];
    end else if (!so[4]) begin
      n = int'(so[11:7]);
      case (so[6:5])
        2'd0: if (n != 0) begin v = rm << n; co = rm[32 - n]; end
        2'd1: if (n == 0) begin v = 32'd0; co = rm[31]; end
              else begin v = rm >> n; co = rm[n - 1]; end
        2'd2: if (n == 0) begin v = {32{rm[31]}}; co = rm[31]; end
              else begin v = $signed(rm) >>> n; co = rm[n - 1]; end
        default: if (n == 0) begin v = {c, rm[31:1]}; co = rm[0]; end
                 else begin v = rotr(rm, n); co = rm[n - 1]; end
      endcase
    end else begin
      n = int'(rs[7:0]);
      if (n != 0) begin
        case (so[6:5])
          2'd0: if (n < 32) begin v = rm << n; co = rm[32 - n]; end
                else if (n == 32) begin v = 32'd0; co = rm[0]; end
                else begin v = 32'd0; co = 1'b0; end
          2'd1: if (n < 32) begin v = rm >> n; co = rm[n - 1]; end
                else if (n == 32) begin v = 32'd0; co = rm[31]; end
                else begin v = 32'd0; co = 1'b0; end
          2'd2: if (n < 32) begin v = $signed(rm) >>> n; co = rm[n - 1]; end
                else begin v = {32{rm[31]}}; co = rm[31]; end
          default: if (n % 32 == 0) begin v = rm; co = rm[31]; end
                   else begin v = rotr(rm, n % 32); co = rm[(n % 32) - 1]; end
        endcase
      end
    end
    return {co, v};
  endfunction

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  // Inputs are stable at the falling edge, so transfers about to happen are known here.
  task automatic scoreboard_step();
    exp_t      e;
    logic [32:0] r;
    if (out_valid_a === 1'b1 && out_ready) begin
      if (q_a.size() == 0) chk("a_spurious_output", 1, 0);
      else begin
        e = q_a.pop_front();
        chk("a_val2", val2_a, e.v);
        chk("a_c_out", c_out_a, e.c);
        chk("a_tag", out_tag_a, e.tag);
      end
    end
    if (out_valid_b === 1'b1 && out_ready) begin
      if (q_b.size() == 0) chk("b_spurious_output", 1, 0);
      else begin
        e = q_b.pop_front();
        chk("b_val2", val2_b, e.v);
        chk("b_c_out", c_out_b, e.c);
        chk("b_tag", out_tag_b, e.tag);
      end
    end
    if (!rst_n || flush) begin
      q_a.delete();
      q_b.delete();
    end else if (in_valid) begin
      if (in_ready_a === 1'b1) begin
        r = ref_op(val_rm, val_rs, shift_operand, imm, mem_mode, c_in, 1'b1);
        q_a.push_back('{v: r[31:0], c: r[32], tag: in_tag});
      end
      if (in_ready_b === 1'b1) begin
        r = ref_op(val_rm, val_rs, shift_operand, imm, mem_mode, c_in, 1'b0);
        q_b.push_back('{v: r[31:0], c: r[32], tag: in_tag});
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    scoreboard_step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fields(input logic [31:0] rm, input logic [31:0] rs, input logic [11:0] so,
                            input logic im, input logic mem, input logic c, input logic [3:0] tag);
    val_rm = rm; val_rs = rs; shift_operand = so;
    imm = im; mem_mode = mem; c_in = c; in_tag = tag;
  endtask

  task automatic randomize_fields();
    logic [31:0] rs;
    rs = $urandom;
    if ($urandom_range(0, 1) == 0) rs[7:0] = 8'($urandom_range(0, 40));
    set_fields($urandom, rs, 12'($urandom_range(0, 4095)), $urandom_range(0, 3) == 0,
               $urandom_range(0, 5) == 0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
  endtask

  task automatic applyStimulus(input logic [31:0] rm, input logic [31:0] rs, input logic [11:0] so,
                               input logic im, input logic mem, input logic c, input logic [3:0] tag);
    set_fields(rm, rs, so, im, mem, c, tag);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  // One-stage pipe shows the result now, the two-stage pipe one cycle later.
  task automatic checkOutput(input string name, input logic [32:0] exp_a, input logic [32:0] exp_b);
    chk({name, "_b_valid"}, out_valid_b, 1);
    chk({name, "_b_val2"}, val2_b, exp_b[31:0]);
    chk({name, "_b_c"}, c_out_b, exp_b[32]);
    tick();
    chk({name, "_a_valid"}, out_valid_a, 1);
    chk({name, "_a_val2"}, val2_a, exp_a[31:0]);
    chk({name, "_a_c"}, c_out_a, exp_a[32]);
  endtask

  initial begin
    logic [32:0] exp1;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    set_fields(32'd0, 32'd0, 12'd0, 1'b0, 1'b0, 1'b0, 4'd0);
    tick();
    tick();
    chk("rst_a_valid", out_valid_a, 0);
    chk("rst_a_val2", val2_a, 0);
    chk("rst_a_c", c_out_a, 0);
    chk("rst_a_tag", out_tag_a, 0);
    chk("rst_b_valid", out_valid_b, 0);
    chk("rst_b_val2", val2_b, 0);
    rst_n = 1'b1;
    chk("rst_a_in_ready", in_ready_a, 1);
    chk("rst_b_in_ready", in_ready_b, 1);

    applyStimulus(32'h1234_5678, 32'd0, 12'h4FF, 1'b1, 1'b0, 1'b0, 4'd1);
    checkOutput("imm_rot", {1'b1, 32'hFF00_0000}, {1'b1, 32'hFF00_0000});
    applyStimulus(32'h8000_0001, 32'd0, 12'h020, 1'b0, 1'b0, 1'b0, 4'd2);
    checkOutput("lsr0", {1'b1, 32'h0}, {1'b1, 32'h0});
    applyStimulus(32'h3, 32'd0, 12'h060, 1'b0, 1'b0, 1'b1, 4'd3);
    checkOutput("rrx", {1'b1, 32'h8000_0001}, {1'b1, 32'h8000_0001});
    applyStimulus(32'hFFFF_FFFF, 32'd32, 12'h010, 1'b0, 1'b0, 1'b0, 4'd4);
    checkOutput("lsl_reg32", {1'b1, 32'h0}, {1'b1, 32'h0});
    applyStimulus(32'hFFFF_FFFF, 32'd33, 12'h010, 1'b0, 1'b0, 1'b1, 4'd5);
    checkOutput("lsl_reg33", {1'b0, 32'h0}, {1'b0, 32'h0});
    applyStimulus(32'hFFFF_FFFF, 32'h0000_0F00, 12'h010, 1'b0, 1'b0, 1'b1, 4'd6);
    checkOutput("lsl_reg0", {1'b1, 32'hFFFF_FFFF}, {1'b1, 32'hFFFF_FFFF});
    applyStimulus(32'h8000_0000, 32'd200, 12'h050, 1'b0, 1'b0, 1'b0, 4'd7);
    checkOutput("asr_reg200", {1'b1, 32'hFFFF_FFFF}, {1'b1, 32'hFFFF_FFFF});
    applyStimulus(32'hDEAD_BEEF, 32'd0, 12'hFFC, 1'b1, 1'b1, 1'b1, 4'd8);
    checkOutput("mem_off", {1'b1, 32'hFFFF_FFFC}, {1'b1, 32'h0000_0FFC});
    tick();

    // Backpressure on the two-stage pipe: capacity two, head held stable.
    out_ready = 1'b0;
    randomize_fields();
    in_tag = 4'd1;
    exp1 = ref_op(val_rm, val_rs, shift_operand, imm, mem_mode, c_in, 1'b1);
    in_valid = 1'b1;
    tick();
    randomize_fields();
    in_tag = 4'd2;
    tick();
    chk("bp_in_ready_low", in_ready_a, 0);
    chk("bp_head_valid", out_valid_a, 1);
    chk("bp_head_tag", out_tag_a, 1);
    randomize_fields();
    in_tag = 4'd3;
    tick();
    tick();
    chk("bp_hold_tag", out_tag_a, 1);
    chk("bp_hold_val2", val2_a, exp1[31:0]);
    chk("bp_hold_c", c_out_a, exp1[32]);
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("bp_order_tag2", out_tag_a, 2);
    tick();
    chk("bp_order_tag3", out_tag_a, 3);
    chk("bp_order_valid3", out_valid_a, 1);
    tick();
    chk("bp_drained", out_valid_a, 0);

    // Flush with two in flight and a concurrent input transfer.
    out_ready = 1'b0;
    in_valid = 1'b1;
    randomize_fields();
    tick();
    randomize_fields();
    tick();
    randomize_fields();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_a_valid", out_valid_a, 0);
    chk("flush_b_valid", out_valid_b, 0);
    chk("flush_a_in_ready", in_ready_a, 1);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("flush_a_quiet", out_valid_a, 0);
    end

    // Same scenario, but with reset instead of flush.
    out_ready = 1'b0;
    in_valid = 1'b1;
    randomize_fields();
    tick();
    randomize_fields();
    tick();
    randomize_fields();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    in_valid = 1'b0;
    chk("rst2_a_valid", out_valid_a, 0);
    chk("rst2_a_val2", val2_a, 0);
    chk("rst2_a_c", c_out_a, 0);
    chk("rst2_a_tag", out_tag_a, 0);
    chk("rst2_b_valid", out_valid_b, 0);
    chk("rst2_b_val2", val2_b, 0);
    out_ready = 1'b1;

    for (int i = 0; i < 400; i++) begin
      randomize_fields();
      in_valid  = $urandom_range(0, 3) != 0;
      out_ready = $urandom_range(0, 3) != 0;
      flush     = $urandom_range(0, 40) == 0;
      tick();
    end

    in_valid = 1'b0;
    flush = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("drain_a_empty", q_a.size(), 0);
    chk("drain_b_empty", q_b.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
